// File: rtl/prim_skid_slice_pkg.sv
// Shared types for the two-entry skid slice: sparse FSM encodings and
// small decode helpers used by the slice control logic.
package prim_skid_slice_pkg;

  localparam int unsigned StateWidth = 5;

  // Every pair of legal encodings differs in at least three bits, so a
  // single or double bit upset can never turn one legal state into another.
  typedef enum logic [StateWidth-1:0] {
    StEmpty = 5'b00000,
    StOne   = 5'b00111,
    StFull  = 5'b11001
  } state_e;

  // Occupancy of the slice for a raw state value; illegal values read as 0.
  function automatic logic [1:0] state_count(logic [StateWidth-1:0] s);
    logic [1:0] cnt;
    cnt = 2'd0;
    if (s == StOne) cnt = 2'd1;
    if (s == StFull) cnt = 2'd2;
    return cnt;
  endfunction

  // True when the raw state value is one of the three legal encodings.
  function automatic logic state_legal(logic [StateWidth-1:0] s);
    return (s == StEmpty) || (s == StOne) || (s == StFull);
  endfunction

endpackage

// File: rtl/prim_skid_slice_flop.sv
// Enable flop used for the slice storage registers, plus the technology
// buffer cell that shields its enable from logic merging when requested.

// Technology buffer model: a plain wire in simulation, mapped to a
// dont-touch buffer cell by the target library.
module tc_clk_buffer (
  input  logic clk_i,
  output logic clk_o
);

  assign clk_o = clk_i;

endmodule

// Width-bit register with load enable and asynchronous active-low reset.
module prim_flop_en #(
  parameter int unsigned      Width      = 1,
  parameter bit               EnSecBuf   = 1'b0,
  parameter logic [Width-1:0] ResetValue = '0
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             en_i,
  input  logic [Width-1:0] d_i,
  output logic [Width-1:0] q_o
);

  logic en;
  logic [Width-1:0] q_reg;

  // Optionally route the enable through a dedicated buffer so two
  // registers with logically equal enables cannot be collapsed.
  if (EnSecBuf) begin : g_en_buf
    tc_clk_buffer u_en_buf (
      .clk_i (en_i),
      .clk_o (en)
    );
  end else begin : g_en_wire
    assign en = en_i;
  end

  // Load d_i only when enabled; reset content is ResetValue.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      q_reg <= ResetValue;
    end else if (en) begin
      q_reg <= d_i;
    end
  end

  assign q_o = q_reg;

endmodule

// File: rtl/prim_skid_slice.sv
// Two-entry skid buffer register slice. ready_o comes straight from a flop,
// so neither valid_i nor ready_i has a combinational path to ready_o, while
// a second (skid) register keeps full throughput. The FSM uses sparse
// encodings; any illegal value raises a sticky err_o and recovers to EMPTY.
module prim_skid_slice
  import prim_skid_slice_pkg::*;
#(
  parameter int unsigned      Width      = 1,
  parameter bit               EnSecBuf   = 1'b0,
  parameter logic [Width-1:0] ResetValue = '0
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             valid_i,
  output logic             ready_o,
  input  logic [Width-1:0] data_i,
  output logic             valid_o,
  input  logic             ready_i,
  output logic [Width-1:0] data_o,
  output logic [1:0]       count_o,
  output logic             err_o
);

  logic [StateWidth-1:0] state_q;
  logic [StateWidth-1:0] state_d;
  logic                  ready_q;
  logic                  ready_d;
  logic                  err_q;
  logic                  err_d;
  logic                  in_xfer;
  logic                  out_xfer;
  logic                  main_en;
  logic                  skid_en;
  logic                  main_from_skid;
  logic [Width-1:0]      main_d;
  logic [Width-1:0]      main_q;
  logic [Width-1:0]      skid_q;

  assign valid_o  = (state_q == StOne) || (state_q == StFull);
  assign in_xfer  = valid_i && ready_q;
  assign out_xfer = valid_o && ready_i;

  // Next state, register enables and error detection. Enables are only
  // raised in the exact cycle the corresponding register loads.
  always_comb begin
    state_d        = state_q;
    main_en        = 1'b0;
    skid_en        = 1'b0;
    main_from_skid = 1'b0;
    err_d          = err_q;
    case (state_q)
      StEmpty: begin
        if (in_xfer) begin
          main_en = 1'b1;
          state_d = StOne;
        end
      end
      StOne: begin
        if (in_xfer && out_xfer) begin
          main_en = 1'b1;
        end else if (in_xfer) begin
          skid_en = 1'b1;
          state_d = StFull;
        end else if (out_xfer) begin
          state_d = StEmpty;
        end
      end
      StFull: begin
        // ready_q is low here, so no word can arrive in this state.
        if (out_xfer) begin
          main_en        = 1'b1;
          main_from_skid = 1'b1;
          state_d        = StOne;
        end
      end
      default: begin
        err_d   = 1'b1;
        state_d = StEmpty;
      end
    endcase
    if (!state_legal(state_q)) begin
      err_d = 1'b1;
    end
  end

  // ready_o for the next cycle depends only on where the FSM is heading.
  always_comb begin
    ready_d = (state_d != StFull);
  end

  assign main_d = main_from_skid ? skid_q : data_i;

  // FSM state register.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= StEmpty;
    end else begin
      state_q <= state_d;
    end
  end

  // Registered ready: held low in reset, rises on the first edge after.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      ready_q <= 1'b0;
    end else begin
      ready_q <= ready_d;
    end
  end

  // Sticky encoding-fault flag.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      err_q <= 1'b0;
    end else begin
      err_q <= err_d;
    end
  end

  prim_flop_en #(
    .Width      (Width),
    .EnSecBuf   (EnSecBuf),
    .ResetValue (ResetValue)
  ) u_main (
    .clk_i  (clk_i),
    .rst_ni (rst_ni),
    .en_i   (main_en),
    .d_i    (main_d),
    .q_o    (main_q)
  );

  prim_flop_en #(
    .Width      (Width),
    .EnSecBuf   (EnSecBuf),
    .ResetValue (ResetValue)
  ) u_skid (
    .clk_i  (clk_i),
    .rst_ni (rst_ni),
    .en_i   (skid_en),
    .d_i    (data_i),
    .q_o    (skid_q)
  );

  assign ready_o = ready_q;
  assign data_o  = main_q;
  assign count_o = state_count(state_q);
  assign err_o   = err_q;

endmodule

// File: tb/tb_prim_skid_slice.sv
// Scoreboard bench for prim_skid_slice: accepted words are queued by the
// stimulus side, a negedge monitor pops and compares every delivered word.
module tb_prim_skid_slice;
  import prim_skid_slice_pkg::*;

  localparam int unsigned W  = 8;
  localparam logic [7:0]  RV = 8'hC3;

  logic       clk_i   = 1'b0;
  logic       rst_ni  = 1'b0;
  logic       valid_i = 1'b0;
  logic       ready_i = 1'b0;
  logic [7:0] data_i  = '0;
  logic       ready_o;
  logic       valid_o;
  logic [7:0] data_o;
  logic [1:0] count_o;
  logic       err_o;

  int pass_cnt  = 0;
  int total_cnt = 0;
  int pop_cnt   = 0;
  logic [7:0] exp_q[$];

  prim_skid_slice #(
    .Width      (W),
    .EnSecBuf   (1'b1),
    .ResetValue (RV)
  ) dut (
    .clk_i   (clk_i),
    .rst_ni  (rst_ni),
    .valid_i (valid_i),
    .ready_o (ready_o),
    .data_i  (data_i),
    .valid_o (valid_o),
    .ready_i (ready_i),
    .data_o  (data_o),
    .count_o (count_o),
    .err_o   (err_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
  endtask

  // Record the word if an upstream handshake is pending at this edge.
  task automatic observe_in();
    if (valid_i && ready_o) begin
      exp_q.push_back(data_i);
      $display("in  0x%02h (queued %0d)", data_i, exp_q.size());
    end
  endtask

  task automatic drive(input logic v, input logic [7:0] d);
    @(posedge clk_i);
    #1;
    valid_i = v;
    data_i  = d;
    @(negedge clk_i);
    observe_in();
  endtask

  // Monitor: every downstream handshake must deliver the oldest queued word.
  always @(negedge clk_i) begin
    logic [7:0] e;
    if (rst_ni && valid_o && ready_i) begin
      if (exp_q.size() == 0) begin
        total_cnt++;
        $display("FAIL unexpected_out: got 0x%0h, expected no word", data_o);
      end else begin
        e = exp_q.pop_front();
        check("data_o", {24'd0, data_o}, {24'd0, e});
        pop_cnt++;
        $display("out 0x%02h (expected 0x%02h)", data_o, e);
      end
    end
  end

  initial begin
    int p0;
    int sent;
    int cycles;
    logic acc;

    // Reset state
    repeat (2) @(negedge clk_i);
    check("rst_valid_o", {31'd0, valid_o}, 32'd0);
    check("rst_ready_o", {31'd0, ready_o}, 32'd0);
    check("rst_count_o", {30'd0, count_o}, 32'd0);
    check("rst_err_o",   {31'd0, err_o},   32'd0);
    check("rst_data_o",  {24'd0, data_o},  {24'd0, RV});
    rst_ni = 1'b1;
    @(posedge clk_i);
    #1;
    check("ready_after_reset", {31'd0, ready_o}, 32'd1);

    // Single word, one cycle latency
    ready_i = 1'b1;
    drive(1'b1, 8'hA5);
    check("a5_ready", {31'd0, ready_o}, 32'd1);
    drive(1'b0, 8'h00);
    check("a5_valid_o", {31'd0, valid_o}, 32'd1);
    check("a5_data_o",  {24'd0, data_o},  32'hA5);
    check("a5_count",   {30'd0, count_o}, 32'd1);
    check("a5_ready2",  {31'd0, ready_o}, 32'd1);
    @(negedge clk_i);
    check("a5_drained", {30'd0, count_o}, 32'd0);

    // Back-pressure fill, then drain
    @(posedge clk_i);
    #1;
    ready_i = 1'b0;
    drive(1'b1, 8'h11);
    drive(1'b1, 8'h22);
    check("fill_ready_one", {31'd0, ready_o}, 32'd1);
    drive(1'b0, 8'h00);
    check("full_count", {30'd0, count_o}, 32'd2);
    check("full_ready", {31'd0, ready_o}, 32'd0);
    check("full_head",  {24'd0, data_o},  32'h11);
    @(posedge clk_i);
    #1;
    ready_i = 1'b1;
    @(negedge clk_i);
    check("drain_count2", {30'd0, count_o}, 32'd2);
    @(negedge clk_i);
    check("drain_count1", {30'd0, count_o}, 32'd1);
    check("drain_data22", {24'd0, data_o},  32'h22);
    @(negedge clk_i);
    check("drain_count0", {30'd0, count_o}, 32'd0);

    // Full-throughput stream of 0..99
    p0 = pop_cnt;
    for (int i = 0; i < 100; i++) begin
      drive(1'b1, i[7:0]);
      if (i > 0) check("stream_count", {30'd0, count_o}, 32'd1);
      check("stream_ready", {31'd0, ready_o}, 32'd1);
    end
    drive(1'b0, 8'h00);
    check("stream_last_count", {30'd0, count_o}, 32'd1);
    @(negedge clk_i);
    check("stream_words_out", pop_cnt - p0, 32'd100);
    check("stream_end_count", {30'd0, count_o}, 32'd0);

    // Random valid/ready, 1000 words
    p0 = pop_cnt;
    sent = 0;
    cycles = 0;
    acc = 1'b0;
    while (sent < 1000 && cycles < 20000) begin
      @(posedge clk_i);
      #1;
      if (acc) valid_i = 1'b0;
      if (!valid_i && ($urandom_range(1, 0) == 1)) begin
        valid_i = 1'b1;
        data_i  = 8'((sent * 37) + 5);
      end
      ready_i = ($urandom_range(1, 0) == 1);
      @(negedge clk_i);
      acc = valid_i && ready_o;
      observe_in();
      if (acc) sent++;
      cycles++;
    end
    check("random_sent", sent, 32'd1000);
    @(posedge clk_i);
    #1;
    valid_i = 1'b0;
    ready_i = 1'b1;
    cycles = 0;
    while (exp_q.size() != 0 && cycles < 10) begin
      @(negedge clk_i);
      cycles++;
    end
    check("random_drain_empty", exp_q.size(), 32'd0);
    check("random_words_out", pop_cnt - p0, 32'd1000);

    // Reset while FULL
    @(posedge clk_i);
    #1;
    ready_i = 1'b0;
    drive(1'b1, 8'h33);
    drive(1'b1, 8'h44);
    drive(1'b0, 8'h00);
    check("prerst_count", {30'd0, count_o}, 32'd2);
    #2;
    rst_ni = 1'b0;
    #1;
    check("midrst_valid_o", {31'd0, valid_o}, 32'd0);
    check("midrst_data_o",  {24'd0, data_o},  {24'd0, RV});
    check("midrst_count_o", {30'd0, count_o}, 32'd0);
    check("midrst_ready_o", {31'd0, ready_o}, 32'd0);
    check("midrst_err_o",   {31'd0, err_o},   32'd0);
    exp_q.delete();
    repeat (2) @(negedge clk_i);
    rst_ni  = 1'b1;
    ready_i = 1'b1;
    repeat (4) @(negedge clk_i);
    check("postrst_no_stale", {31'd0, valid_o}, 32'd0);
    check("postrst_ready",    {31'd0, ready_o}, 32'd1);

    // Illegal state encoding
    @(negedge clk_i);
    force dut.state_q = 5'b10101;
    @(posedge clk_i);
    #1;
    release dut.state_q;
    @(negedge clk_i);
    check("illegal_err_next", {31'd0, err_o},   32'd1);
    check("illegal_valid_lo", {31'd0, valid_o}, 32'd0);
    @(negedge clk_i);
    check("illegal_state_empty", {27'd0, dut.state_q}, {27'd0, StEmpty});
    check("illegal_count",       {30'd0, count_o},     32'd0);
    check("illegal_ready",       {31'd0, ready_o},     32'd1);
    check("illegal_err_sticky",  {31'd0, err_o},       32'd1);
    p0 = pop_cnt;
    drive(1'b1, 8'h5A);
    drive(1'b0, 8'h00);
    check("recover_valid", {31'd0, valid_o}, 32'd1);
    check("recover_data",  {24'd0, data_o},  32'h5A);
    repeat (3) @(negedge clk_i);
    check("recover_delivered", pop_cnt - p0, 32'd1);
    check("err_still_set", {31'd0, err_o}, 32'd1);
    check("final_queue_empty", exp_q.size(), 32'd0);

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule

// File: doc/prim_skid_slice.md
PRIM_SKID_SLICE -- requirements
Module: prim_skid_slice

Interface
REQ-001: Parameter Width, default 1, payload width in bits (>=1).
REQ-002: Parameter EnSecBuf, default 0, when 1 every storage-register enable SHALL pass through a tc_clk_buffer instance so synthesis cannot merge it.
REQ-003: Parameter ResetValue, default 0, Width-bit reset content of both storage registers.
REQ-004: clk_i  input  1  clock; all state updates on rising edge.
REQ-005: rst_ni  input  1  reset, asynchronous, active-low.
REQ-006: valid_i  input  1  upstream offers data_i this cycle.
REQ-007: ready_o  output  1  slice accepts upstream word this cycle.
REQ-008: data_i  input  Width  upstream payload.
REQ-009: valid_o  output  1  slice offers data_o downstream.
REQ-010: ready_i  input  1  downstream accepts data_o this cycle.
REQ-011: data_o  output  Width  downstream payload.
REQ-012: count_o  output  2  occupancy, 0..2.
REQ-013: err_o  output  1  state-encoding fault flag, sticky until reset.

Function
REQ-014: Transfer in SHALL occur when valid_i && ready_o; transfer out SHALL occur when valid_o && ready_i.
REQ-015: Storage SHALL be a main register (drives data_o) and a skid register; capacity 2 words.
REQ-016: FSM states SHALL be EMPTY, ONE, FULL, with sparse encodings of Hamming distance >=3 between states.
REQ-017: ready_o SHALL be a registered signal equal to (state != FULL), with no combinational path from ready_i or valid_i.
REQ-018: valid_o SHALL equal (state == ONE || state == FULL); count_o SHALL be 0/1/2 for EMPTY/ONE/FULL.
REQ-019: EMPTY, transfer in: main <= data_i, go to ONE; latency valid_i to valid_o is exactly 1 cycle.
REQ-020: ONE, transfer in and out simultaneously: main <= data_i, stay in ONE.
REQ-021: ONE, transfer in only: skid <= data_i, go to FULL.
REQ-022: ONE, transfer out only: go to EMPTY, main keeps its value.
REQ-023: FULL, transfer out: main <= skid, go to ONE; no transfer in is possible in FULL.
REQ-024: Words SHALL leave in strict arrival order, with no loss or duplication under any valid_i/ready_i pattern.
REQ-025: Full-throughput operation SHALL be sustained: with valid_i=ready_i=1 continuously, one word per cycle passes after the first.
REQ-026: A register enable SHALL be asserted only in cycles where that register loads.
REQ-027: On any state value outside the three legal encodings, err_o <= 1, the FSM SHALL go to EMPTY, ready_o <= 1, and valid_o SHALL be low from the next cycle.
REQ-028: valid_i or data_i changing without a handshake SHALL NOT alter state; upstream protocol violations are not checked.

Reset
REQ-029: Assertion of rst_ni, including mid-transfer, SHALL immediately force: state=EMPTY, main=skid=ResetValue, data_o=ResetValue, valid_o=0, count_o=0, err_o=0, ready_o=0.
REQ-030: ready_o SHALL rise on the first clk_i edge after rst_ni deasserts; words in flight at reset are discarded.

Structure
REQ-031: The state enum type and its sparse encoding constants SHALL live in shared package prim_skid_slice_pkg.
REQ-032: Both storage registers SHALL be prim_flop_en instances (Width, EnSecBuf, ResetValue passed through); there SHALL be no other sub-module.
REQ-033: The state register SHALL be a separate always_ff block with asynchronous reset.

Verification
REQ-034: Reset, then valid_i=1, data_i=0xA5, ready_i=1 -> valid_o=1, data_o=0xA5 next cycle; ready_o=1 throughout.
REQ-035: ready_i=0, push 0x11 then 0x22 -> count_o=2, ready_o=0; then ready_i=1 -> outputs 0x11 then 0x22 on consecutive cycles, count_o 2->1->0.
REQ-036: Stream 0..99 with valid_i=ready_i=1 -> 100 words out in order in 101 cycles, count_o stays 1 after the first.
REQ-037: Random valid_i/ready_i (50%), 1000 words -> scoreboard shows order preserved and no loss or duplication.
REQ-038: Assert rst_ni with FULL (0x33, 0x44) -> valid_o=0, data_o=ResetValue, count_o=0 immediately; no stale word after release.
REQ-039: Force the state to an illegal encoding -> err_o=1 next cycle and stays 1, state=EMPTY; the next push of 0x5A is delivered normally.
